register_file: RTL and testbench
================================

# register_file

ARMv7-A style banked general-purpose register file for the miniARMv7 core. It holds the 16 architecturally visible registers R0–R15 and the mode-banked copies of R8–R14. It has three combinational read ports and one synchronous write port, plus a dedicated PC update path. It sits between decode/execute and the CPSR mode logic, and flags unsupported processor modes.

## Interface
- No parameters.
- Clock/reset: one clock; reset is asynchronous and active-high.
- CP  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- mode  in  5  current processor mode (CPSR[4:0]); selects the register bank.
- addrA, addrB, addrC  in  4 each  read addresses.
- addrW  in  4  write address.
- dataW  in  32  write data.
- regW  in  1  write enable for addrW.
- dataPC  in  32  next PC value.
- regPC  in  1  PC write enable.
- err  out  1  high when mode is not a supported mode.
- dataA, dataB, dataC  out  32 each  read data.

## Operation
- Supported modes:
  - USR 10000
  - FIQ 10001
  - IRQ 10010
  - SVC 10011
  - ABT 10111
  - UND 11011
  - SYS 11111
- Any other mode value sets err=1. This includes 11010 (HYP).
- Physical storage:
  - R0–R7: shared by all modes.
  - R8–R12: user copy plus an FIQ copy.
  - R13–R14: user/system copy plus one copy each for FIQ, IRQ, SVC, ABT and UND.
  - R15 (PC): a single shared register.
- Bank selection:
  - USR and SYS use the user copies.
  - FIQ uses the FIQ R8–R14.
  - IRQ, SVC, ABT and UND use their own R13/R14 and the user R8–R12.
- Reads:
  - Purely combinational from addr* and mode.
  - Address 15 returns the stored PC unmodified; there is no +8 offset.
  - When err=1, dataA, dataB and dataC return 0.
- Writes, on the rising edge of CP:
  - If regW=1 and err=0, dataW is written to the register at addrW in the current mode's bank.
  - If regPC=1, PC is loaded with dataPC. This happens regardless of err.
  - If regW=1 with addrW=15 and regPC=1 in the same cycle, the regW write wins: PC gets dataW.
- err is combinational from mode only.

## Timing
- Reset asynchronously clears every physical register, including all banked copies and PC, to 0x00000000.
  - Outputs therefore read 0 during and after reset.
  - err follows mode even during reset.
- Write latency is one edge: a value written at an edge is visible on the read ports immediately after that edge.
- No write-to-read bypass. A read of the register being written returns the old value until the edge.
- A mode change takes effect on the read ports combinationally, in the same cycle.
- A write uses the mode present at the edge.
- Reset asserted mid-operation overrides any pending write.

## Configuration
- RF_FIQ_BANK_EN:
  - Defined: FIQ mode has private R8–R12 as described above.
  - Undefined: the FIQ copies of R8–R12 are not implemented and FIQ mode uses the user R8–R12. FIQ still has private R13/R14.
  - Everything else is identical in both builds.

## Test plan
- Common setup for scenarios 1–4: reset pulse, mode=10000, addrA=0, addrB=8, addrC=15.
- 1. Write R0 and PC, then read:
  - Stimulus: dataW=123, addrW=0, regW=1, dataPC=22, regPC=1.
  - Response after the edge: dataA=123, dataC=22, err=0.
- 2. FIQ banking:
  - Stimulus: write R8=456 in USR with dataPC=23. Then set mode=10001, regW=0.
  - Response: dataB=0 with the macro defined, dataB=456 without it; dataC=23.
  - Stimulus: in FIQ write R8=789 with dataPC=24.
  - Response: dataB=789, dataC=24.
  - Stimulus: return to mode=10000.
  - Response: dataB=456.
- 3. PC write priority:
  - Stimulus: addrW=15, dataW=333, regW=1, dataPC=25, regPC=1.
  - Response after the edge: dataC=333.
- 4. Invalid mode:
  - Stimulus: mode=11010, then write dataW=123 to addrW=14.
  - Response: err=1 and dataA/dataB/dataC=0.
  - Stimulus: set mode=10000 and read R14.
  - Response: R14 is unchanged (0).
- 5. SVC R13 banking:
  - Stimulus: write R13=0x1000 in USR, then R13=0x2000 in mode 10011.
  - Response: reads return 0x2000 in SVC and 0x1000 in USR and SYS; in IRQ, R13 reads 0.
- 6. Asynchronous reset:
  - Stimulus: after writing R0=123, assert reset between clock edges.
  - Response: dataA=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_file.sv
// Banked ARMv7-A general-purpose register file: R0-R15 plus mode-banked R8-R14.
// Define RF_FIQ_BANK_EN to give FIQ mode its own R8-R12.
module register_file (
  input  logic        CP,
  input  logic        reset,
  input  logic [4:0]  mode,
  input  logic [3:0]  addrA,
  input  logic [3:0]  addrB,
  input  logic [3:0]  addrC,
  input  logic [3:0]  addrW,
  input  logic [31:0] dataW,
  input  logic        regW,
  input  logic [31:0] dataPC,
  input  logic        regPC,
  output logic        err,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [31:0] dataC
);

  typedef enum logic [2:0] {
    BANK_USR = 3'd0,
    BANK_FIQ = 3'd1,
    BANK_IRQ = 3'd2,
    BANK_SVC = 3'd3,
    BANK_ABT = 3'd4,
    BANK_UND = 3'd5
  } bank_t;

  bank_t       bank;
  logic        modeOk;

  logic [31:0] lowRegs [0:12];
  logic [31:0] r13Bank [0:5];
  logic [31:0] r14Bank [0:5];
  logic [31:0] pc;
`ifdef RF_FIQ_BANK_EN
  logic [31:0] fiqRegs [0:4];
`endif

  // USR and SYS share the user bank; anything unlisted (HYP included) is an error.
  always_comb begin
    bank   = BANK_USR;
    modeOk = 1'b1;
    case (mode)
      5'b10000, 5'b11111: bank = BANK_USR;
      5'b10001:           bank = BANK_FIQ;
      5'b10010:           bank = BANK_IRQ;
      5'b10011:           bank = BANK_SVC;
      5'b10111:           bank = BANK_ABT;
      5'b11011:           bank = BANK_UND;
      default:            modeOk = 1'b0;
    endcase
  end

  assign err = ~modeOk;

  function automatic logic [31:0] readReg(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 4'd15)
      v = pc;
    else if (a == 4'd14)
      v = r14Bank[bank];
    else if (a == 4'd13)
      v = r13Bank[bank];
`ifdef RF_FIQ_BANK_EN
    else if (a[3] && (bank == BANK_FIQ))
      v = fiqRegs[a[2:0]];
`endif
    else
      v = lowRegs[a];
    return v;
  endfunction

  always_comb begin
    dataA = '0;
    dataB = '0;
    dataC = '0;
    if (modeOk) begin
      dataA = readReg(addrA);
      dataB = readReg(addrB);
      dataC = readReg(addrC);
    end
  end

  // A general write to R15 is placed after the PC update so it takes priority.
  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) lowRegs[i] <= '0;
      for (int i = 0; i < 6; i++) begin
        r13Bank[i] <= '0;
        r14Bank[i] <= '0;
      end
`ifdef RF_FIQ_BANK_EN
      for (int i = 0; i < 5; i++) fiqRegs[i] <= '0;
`endif
      pc <= '0;
    end else begin
      if (regPC)
        pc <= dataPC;
      if (regW && modeOk) begin
        case (addrW)
          4'd15: pc <= dataW;
          4'd14: r14Bank[bank] <= dataW;
          4'd13: r13Bank[bank] <= dataW;
          default: begin
`ifdef RF_FIQ_BANK_EN
            if (addrW[3] && (bank == BANK_FIQ))
              fiqRegs[addrW[2:0]] <= dataW;
            else
              lowRegs[addrW] <= dataW;
`else
            lowRegs[addrW] <= dataW;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver queues expected reads from a
// physical-storage model, a negedge monitor pops and compares.
module tb_register_file;

  logic        CP;
  logic        reset;
  logic [4:0]  mode;
  logic [3:0]  addrA, addrB, addrC, addrW;
  logic [31:0] dataW, dataPC;
  logic        regW, regPC;
  logic        err;
  logic [31:0] dataA, dataB, dataC;

  register_file dut (
    .CP(CP), .reset(reset), .mode(mode),
    .addrA(addrA), .addrB(addrB), .addrC(addrC), .addrW(addrW),
    .dataW(dataW), .regW(regW), .dataPC(dataPC), .regPC(regPC),
    .err(err), .dataA(dataA), .dataB(dataB), .dataC(dataC)
  );

`ifdef RF_FIQ_BANK_EN
  localparam bit FIQ_BANK = 1'b1;
`else
  localparam bit FIQ_BANK = 1'b0;
`endif

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                         SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011,
                         SYS = 5'b11111, HYP = 5'b11010;

  typedef struct {
    logic [31:0] a, b, c;
    logic        e;
    int          id;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [int];
  int          checks   = 0;
  int          failures = 0;
  int          seq      = 0;

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic bit modeValid(input logic [4:0] md);
    return md inside {USR, FIQ, IRQ, SVC, ABT, UND, SYS};
  endfunction

  // Identify the physical storage cell that (mode, reg) refers to.
  function automatic int physKey(input logic [4:0] md, input logic [3:0] r);
    int bk;
    case (md)
      FIQ:     bk = 1;
      IRQ:     bk = 2;
      SVC:     bk = 3;
      ABT:     bk = 4;
      UND:     bk = 5;
      default: bk = 0;
    endcase
    if (r == 4'd15) return 15;
    if (r >= 4'd13) return 200 + bk * 16 + int'(r);
    if (r >= 4'd8 && md == FIQ && FIQ_BANK) return 100 + int'(r);
    return int'(r);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] md, input logic [3:0] r);
    int k;
    if (!modeValid(md)) return '0;
    k = physKey(md, r);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%h expected=%h", nm, id, act, exp);
    end
  endtask

  always @(negedge CP) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("dataA", x.id, dataA, x.a);
      chk("dataB", x.id, dataB, x.b);
      chk("dataC", x.id, dataC, x.c);
      chk("err",   x.id, {31'b0, err}, {31'b0, x.e});
    end
  end

  task automatic cycle(input logic rst, input logic [4:0] md,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] w, input logic [31:0] dw, input logic rw,
                       input logic [31:0] dpc, input logic rpc);
    exp_t e;
    @(posedge CP);
    #1;
    reset = rst; mode = md;
    addrA = a; addrB = b; addrC = c;
    addrW = w; dataW = dw; regW = rw;
    dataPC = dpc; regPC = rpc;
    if (rst) mem.delete();
    e.a = mread(md, a);
    e.b = mread(md, b);
    e.c = mread(md, c);
    e.e = !modeValid(md);
    e.id = seq++;
    q.push_back(e);
    if (!rst) begin
      if (rpc) mem[15] = dpc;
      if (rw && modeValid(md)) mem[physKey(md, w)] = dw;
    end
  endtask

  task automatic idle(input logic [4:0] md, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    cycle(1'b0, md, a, b, c, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] md;
    reset = 1'b1; mode = USR;
    addrA = 0; addrB = 8; addrC = 15; addrW = 0;
    dataW = 0; regW = 0; dataPC = 0; regPC = 0;

    // Reset pulse, then write R0 and PC
    cycle(1'b1, USR, 0, 8, 15, 0, 0, 0, 0, 0);
    cycle(1'b0, USR, 0, 8, 15, 0, 32'd123, 1, 32'd22, 1);
    idle(USR, 0, 8, 15);

    // FIQ banking of R8
    cycle(1'b0, USR, 0, 8, 15, 8, 32'd456, 1, 32'd23, 1);
    idle(FIQ, 0, 8, 15);
    cycle(1'b0, FIQ, 0, 8, 15, 8, 32'd789, 1, 32'd24, 1);
    idle(FIQ, 0, 8, 15);
    idle(USR, 0, 8, 15);

    // regW to R15 beats regPC
    cycle(1'b0, USR, 0, 8, 15, 15, 32'd333, 1, 32'd25, 1);
    idle(USR, 0, 8, 15);

    // Invalid mode blocks writes and zeroes reads
    cycle(1'b0, HYP, 0, 8, 15, 14, 32'd123, 1, 32'd0, 0);
    idle(HYP, 0, 14, 15);
    idle(USR, 0, 14, 15);

    // SVC R13 banking
    cycle(1'b0, USR, 13, 14, 15, 13, 32'h1000, 1, 32'd0, 0);
    cycle(1'b0, SVC, 13, 14, 15, 13, 32'h2000, 1, 32'd0, 0);
    idle(SVC, 13, 14, 15);
    idle(USR, 13, 14, 15);
    idle(SYS, 13, 14, 15);
    idle(IRQ, 13, 14, 15);

    // Asynchronous reset mid-cycle; err still follows mode during reset
    cycle(1'b0, USR, 0, 13, 15, 0, 32'd123, 1, 32'd0, 0);
    idle(USR, 0, 13, 15);
    cycle(1'b1, USR, 0, 13, 15, 0, 32'd77, 1, 32'd9, 1);
    cycle(1'b1, HYP, 0, 13, 15, 0, 32'd77, 1, 32'd9, 1);
    idle(USR, 0, 13, 15);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: md = USR; 1: md = FIQ; 2: md = IRQ; 3: md = SVC;
        4: md = ABT; 5: md = UND; 6: md = SYS; 7: md = HYP;
        default: md = 5'($urandom);
      endcase
      cycle(($urandom_range(0, 49) == 0), md,
            4'($urandom), 4'($urandom_range(8, 15)), 4'($urandom),
            4'($urandom), $urandom, ($urandom_range(0, 1) == 1),
            $urandom, ($urandom_range(0, 3) == 0));
    end

    @(posedge CP);
    @(negedge CP);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
